// File: rtl/conv33_bias_seq_if.sv
// conv33_bias_seq_if: parameter-load and bias-issue handshake bundle for the bias sequencer
interface conv33_bias_seq_if #(parameter int BIAS_WIDTH = 16, parameter int OC_W = 6);
  logic [OC_W:0]       cfg_num_oc;
  logic                load_start;
  logic                load_en;
  logic [BIAS_WIDTH-1:0] load_data;
  logic                load_done;
  logic                run_start;
  logic                ch_done;
  logic [BIAS_WIDTH-1:0] bias;
  logic [OC_W-1:0]     oc_idx;
  logic                bias_valid;
  logic                all_done;
  logic                busy;
  logic                err;
  modport master (
    output cfg_num_oc, load_start, load_en, load_data, run_start, ch_done,
    input  load_done, bias, oc_idx, bias_valid, all_done, busy, err
  );
  modport slave (
    input  cfg_num_oc, load_start, load_en, load_data, run_start, ch_done,
    output load_done, bias, oc_idx, bias_valid, all_done, busy, err
  );
endinterface

// File: rtl/conv33_bias_seq.sv
// conv33_bias_seq: loads per-OC bias words into a register file, then issues them one per output channel
module conv33_bias_seq #(
  parameter int BIAS_WIDTH = 16,
  parameter int MAX_OC     = 64,
  parameter int OC_W       = 6
) (
  input logic clk,
  input logic rst_n,
  conv33_bias_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, READY, ISSUE, WAIT, DONE} state_t;
  state_t state_q, state_d;
  logic [OC_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, oc_idx_q, oc_idx_d;
  logic [OC_W:0] n_q, n_d;
  logic [BIAS_WIDTH-1:0] rd_q, rd_d, bias_q, bias_d;
  logic pend_q, pend_d, bias_valid_q, bias_valid_d, load_done_q, load_done_d;
  logic all_done_q, all_done_d, busy_q, busy_d, err_q, err_d;
  logic [BIAS_WIDTH-1:0] rf [MAX_OC];
  logic cfg_ok, last_wr, last_rd, we;
  assign cfg_ok  = bus.cfg_num_oc != '0 && bus.cfg_num_oc <= (OC_W+1)'(MAX_OC);
  assign last_wr = {1'b0, wr_ptr_q} == n_q - 1'b1;
  assign last_rd = {1'b0, rd_ptr_q} == n_q - 1'b1;
  assign we      = state_q == LOAD && bus.load_en;
  // rf read is registered (rd_q) in ISSUE; pend_q marks the cycle before it reaches the bias output
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    n_d          = n_q;
    rd_d         = rd_q;
    pend_d       = 1'b0;
    bias_d       = pend_q ? rd_q : bias_q;
    oc_idx_d     = pend_q ? rd_ptr_q : oc_idx_q;
    bias_valid_d = pend_q;
    load_done_d  = 1'b0;
    all_done_d   = 1'b0;
    err_d        = bus.load_en && state_q != LOAD;
    case (state_q)
      IDLE: if (bus.load_start) begin
        err_d    = err_d | !cfg_ok;
        n_d      = cfg_ok ? bus.cfg_num_oc : n_q;
        wr_ptr_d = '0;
        state_d  = cfg_ok ? LOAD : IDLE;
      end
      LOAD: if (bus.load_en) begin
        wr_ptr_d    = wr_ptr_q + 1'b1;
        load_done_d = last_wr;
        state_d     = last_wr ? READY : LOAD;
      end
      READY: if (bus.run_start) begin
        rd_ptr_d = '0;
        state_d  = ISSUE;
      end else if (bus.load_start) begin
        err_d    = err_d | !cfg_ok;
        n_d      = cfg_ok ? bus.cfg_num_oc : n_q;
        wr_ptr_d = '0;
        state_d  = cfg_ok ? LOAD : READY;
      end
      ISSUE: begin
        rd_d    = rf[rd_ptr_q];
        pend_d  = 1'b1;
        state_d = WAIT;
      end
      WAIT: if (bus.ch_done && !pend_q) begin
        rd_ptr_d = last_rd ? rd_ptr_q : rd_ptr_q + 1'b1;
        state_d  = last_rd ? DONE : ISSUE;
      end
      DONE: begin
        all_done_d = 1'b1;
        state_d    = READY;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d inside {LOAD, ISSUE, WAIT, DONE};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      n_q          <= '0;
      rd_q         <= '0;
      pend_q       <= 1'b0;
      bias_q       <= '0;
      oc_idx_q     <= '0;
      bias_valid_q <= 1'b0;
      load_done_q  <= 1'b0;
      all_done_q   <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      n_q          <= n_d;
      rd_q         <= rd_d;
      pend_q       <= pend_d;
      bias_q       <= bias_d;
      oc_idx_q     <= oc_idx_d;
      bias_valid_q <= bias_valid_d;
      load_done_q  <= load_done_d;
      all_done_q   <= all_done_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) rf[wr_ptr_q] <= bus.load_data;
  end
  assign bus.bias       = bias_q;
  assign bus.oc_idx     = oc_idx_q;
  assign bus.bias_valid = bias_valid_q;
  assign bus.load_done  = load_done_q;
  assign bus.all_done   = all_done_q;
  assign bus.busy       = busy_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_conv33_bias_seq.sv
// tb_conv33_bias_seq: self-checking bench for the bias sequencer against an array-based model
module tb_conv33_bias_seq;
  localparam int BW = 16, MAX_OC = 64, OC_W = 6;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  conv33_bias_seq_if #(.BIAS_WIDTH(BW), .OC_W(OC_W)) bus();
  conv33_bias_seq #(.BIAS_WIDTH(BW), .MAX_OC(MAX_OC), .OC_W(OC_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  typedef struct {
    logic [6:0] cfg;
    logic       ld_en;
    logic       exp_err;
    logic       exp_busy;
  } vec_t;
  vec_t vt [6];
  logic [BW-1:0] mdl [MAX_OC];
  logic [BW-1:0] stim [MAX_OC];
  int pass_cnt = 0, total_cnt = 0;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    else pass_cnt++;
  endtask
  task automatic chk_quiet(string nm);
    chk({nm, "_bias"}, 32'(bus.bias), 0);
    chk({nm, "_oc_idx"}, 32'(bus.oc_idx), 0);
    chk({nm, "_bias_valid"}, 32'(bus.bias_valid), 0);
    chk({nm, "_load_done"}, 32'(bus.load_done), 0);
    chk({nm, "_all_done"}, 32'(bus.all_done), 0);
    chk({nm, "_busy"}, 32'(bus.busy), 0);
    chk({nm, "_err"}, 32'(bus.err), 0);
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask
  task automatic load(int n, int gap);
    int g;
    bus.cfg_num_oc = 7'(n);
    bus.load_start = 1'b1;
    tick;
    bus.load_start = 1'b0;
    chk("load_busy", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      bus.load_en   = 1'b1;
      bus.load_data = stim[i];
      tick;
      bus.load_en = 1'b0;
      mdl[i] = stim[i];
      chk("load_done", 32'(bus.load_done), 32'(i == n - 1));
      g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      if (i != n - 1) repeat (g) begin
        tick;
        chk("load_done_gap", 32'(bus.load_done), 0);
      end
    end
    tick;
    chk("load_done_pulse", 32'(bus.load_done), 0);
    chk("ready_busy", 32'(bus.busy), 0);
  endtask
  task automatic run(int n, int d, bit with_ld);
    int dd;
    bus.run_start  = 1'b1;
    bus.load_start = with_ld;
    bus.cfg_num_oc = 7'd2;
    tick;
    bus.run_start  = 1'b0;
    bus.load_start = 1'b0;
    chk("run_busy", 32'(bus.busy), 1);
    for (int i = 0; i < n; i++) begin
      tick;
      chk("pre_valid", 32'(bus.bias_valid), 0);
      tick;
      chk("bias_valid", 32'(bus.bias_valid), 1);
      chk("bias", 32'(bus.bias), 32'(mdl[i]));
      chk("oc_idx", 32'(bus.oc_idx), 32'(i));
      dd = d < 0 ? int'($urandom_range(0, 3)) : d;
      repeat (dd) begin
        tick;
        chk("valid_pulse", 32'(bus.bias_valid), 0);
        chk("bias_hold", 32'(bus.bias), 32'(mdl[i]));
      end
      bus.ch_done = 1'b1;
      tick;
      bus.ch_done = 1'b0;
    end
    chk("all_done_early", 32'(bus.all_done), 0);
    tick;
    chk("all_done", 32'(bus.all_done), 1);
    tick;
    chk("all_done_pulse", 32'(bus.all_done), 0);
    chk("end_busy", 32'(bus.busy), 0);
  endtask
  initial begin
    int n, cnt;
    vt[0] = '{7'd0,   1'b0, 1'b1, 1'b0};
    vt[1] = '{7'd65,  1'b0, 1'b1, 1'b0};
    vt[2] = '{7'd127, 1'b0, 1'b1, 1'b0};
    vt[3] = '{7'd1,   1'b0, 1'b0, 1'b1};
    vt[4] = '{7'd64,  1'b0, 1'b0, 1'b1};
    vt[5] = '{7'd5,   1'b1, 1'b1, 1'b1};
    bus.cfg_num_oc = '0;
    bus.load_start = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_data  = '0;
    bus.run_start  = 1'b0;
    bus.ch_done    = 1'b0;
    do_reset;
    chk_quiet("reset");
    for (int i = 0; i < 6; i++) begin
      bus.cfg_num_oc = vt[i].cfg;
      bus.load_start = 1'b1;
      bus.load_en    = vt[i].ld_en;
      tick;
      bus.load_start = 1'b0;
      bus.load_en    = 1'b0;
      chk($sformatf("cfg%0d_err", i), 32'(bus.err), 32'(vt[i].exp_err));
      chk($sformatf("cfg%0d_busy", i), 32'(bus.busy), 32'(vt[i].exp_busy));
      tick;
      chk($sformatf("cfg%0d_err_pulse", i), 32'(bus.err), 0);
      do_reset;
    end
    for (int i = 0; i < 4; i++) stim[i] = 16'(16 * (i + 1));
    load(4, 1);
    run(4, 3, 1'b0);
    bus.load_en   = 1'b1;
    bus.load_data = 16'hdead;
    tick;
    bus.load_en = 1'b0;
    chk("ready_load_en_err", 32'(bus.err), 1);
    tick;
    chk("ready_err_pulse", 32'(bus.err), 0);
    run(4, 3, 1'b0);
    run(4, 0, 1'b1);
    bus.run_start = 1'b1;
    tick;
    bus.run_start = 1'b0;
    tick;
    tick;
    chk("t1_first_valid", 32'(bus.bias_valid), 1);
    tick;
    do_reset;
    chk_quiet("mid_wait_reset");
    bus.run_start = 1'b1;
    tick;
    bus.run_start = 1'b0;
    cnt = 0;
    repeat (6) begin
      tick;
      cnt += int'(bus.bias_valid);
    end
    chk("run_after_reset_valids", 32'(cnt), 0);
    chk("run_after_reset_busy", 32'(bus.busy), 0);
    for (int i = 0; i < MAX_OC; i++) stim[i] = 16'(i);
    load(MAX_OC, 0);
    run(MAX_OC, 0, 1'b0);
    repeat (4) begin
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) stim[i] = 16'($urandom);
      load(n, -1);
      run(n, -1, 1'b0);
      run(n, -1, 1'b0);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
